// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester, transmitter and status signals around uart_tx_arbiter.
// slave: the arbiter's view. master: the client/transmitter side.
interface uart_tx_arbiter_if #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 32
);
    logic [N_REQ-1:0]        Req;
    logic [N_REQ*DATA_W-1:0] Req_Data;
    logic                    Tx_busy;
    logic [N_REQ-1:0]        Grant;
    logic [N_REQ-1:0]        Ack;
    logic [DATA_W-1:0]       Tx_data;
    logic                    Tx_start;
    logic                    Tx_err;
    logic                    Arb_busy;

    modport slave (
        input  Req, Req_Data, Tx_busy,
        output Grant, Ack, Tx_data, Tx_start, Tx_err, Arb_busy
    );

    modport master (
        output Req, Req_Data, Tx_busy,
        input  Grant, Ack, Tx_data, Tx_start, Tx_err, Arb_busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ requesters.
// Optional start-handshake watchdog: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic             Clock_In,
    input  logic             Reset,
    uart_tx_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("uart_tx_arbiter: N_REQ must be 2..8");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT_CYC must be at least 2");
    end

    typedef enum logic [1:0] {StIdle, StStart, StBusy, StDone} state_e;

    state_e            r_state, w_state_d;
    logic              r_sync1, r_busy_s;
    logic [PTR_W-1:0]  r_ptr, w_ptr_d;
    logic [PTR_W-1:0]  r_gnt_idx, w_gnt_idx_d;
    logic [N_REQ-1:0]  r_grant, w_grant_d;
    logic [N_REQ-1:0]  r_ack, w_ack_d;
    logic [DATA_W-1:0] r_tx_data, w_tx_data_d;
    logic              r_tx_start, w_tx_start_d;
    logic              r_arb_busy, w_arb_busy_d;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic             r_tx_err, w_tx_err_d;
`endif

    logic [DATA_W-1:0] w_words [N_REQ];
    logic              w_sel_valid;
    logic [PTR_W-1:0]  w_sel_idx;
    logic [PTR_W-1:0]  w_cand_idx;
    int                w_cand;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_words
        assign w_words[gi] = bus.Req_Data[gi*DATA_W +: DATA_W];
    end

    // Two-flop synchronizer for the transmitter's busy flag
    always_ff @(posedge Clock_In or negedge Reset) begin
        if (!Reset) begin
            r_sync1  <= 1'b0;
            r_busy_s <= 1'b0;
        end else begin
            r_sync1  <= bus.Tx_busy;
            r_busy_s <= r_sync1;
        end
    end

    // Cyclic first-set search from r_ptr; scanning backwards lets the nearest hit win
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_idx   = '0;
        w_cand      = 0;
        w_cand_idx  = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            w_cand = int'(r_ptr) + i;
            if (w_cand >= int'(N_REQ)) begin
                w_cand = w_cand - int'(N_REQ);
            end
            w_cand_idx = PTR_W'(w_cand);
            if (bus.Req[w_cand_idx]) begin
                w_sel_valid = 1'b1;
                w_sel_idx   = w_cand_idx;
            end
        end
    end

    // Next-state and registered-output logic for the grant/handshake FSM
    always_comb begin
        w_state_d    = r_state;
        w_ptr_d      = r_ptr;
        w_gnt_idx_d  = r_gnt_idx;
        w_grant_d    = r_grant;
        w_ack_d      = '0;
        w_tx_data_d  = r_tx_data;
        w_tx_start_d = r_tx_start;
`ifdef UART_ARB_TIMEOUT_EN
        w_cnt_d      = r_cnt;
        w_tx_err_d   = 1'b0;
`endif
        unique case (r_state)
            StIdle: begin
                if (w_sel_valid) begin
                    w_gnt_idx_d  = w_sel_idx;
                    w_grant_d    = N_REQ'(1) << w_sel_idx;
                    w_tx_data_d  = w_words[w_sel_idx];
                    w_tx_start_d = 1'b1;
                    w_state_d    = StStart;
`ifdef UART_ARB_TIMEOUT_EN
                    w_cnt_d      = '0;
`endif
                end
            end
            StStart: begin
                if (r_busy_s) begin
                    w_tx_start_d = 1'b0;
                    w_state_d    = StBusy;
`ifdef UART_ARB_TIMEOUT_EN
                end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    // Transmitter never took the frame: abort and release the owner
                    w_tx_start_d = 1'b0;
                    w_ack_d      = r_grant;
                    w_tx_err_d   = 1'b1;
                    w_state_d    = StDone;
                end else begin
                    w_cnt_d      = r_cnt + 1'b1;
`endif
                end
            end
            StBusy: begin
                // Ack is registered on entry so it is high exactly during DONE
                if (!r_busy_s) begin
                    w_ack_d   = r_grant;
                    w_state_d = StDone;
                end
            end
            StDone: begin
                w_ptr_d   = (r_gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : r_gnt_idx + 1'b1;
                w_grant_d = '0;
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
        w_arb_busy_d = (w_state_d != StIdle);
    end

    // State and output registers
    always_ff @(posedge Clock_In or negedge Reset) begin
        if (!Reset) begin
            r_state    <= StIdle;
            r_ptr      <= '0;
            r_gnt_idx  <= '0;
            r_grant    <= '0;
            r_ack      <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_arb_busy <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            r_cnt      <= '0;
            r_tx_err   <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_d;
            r_ptr      <= w_ptr_d;
            r_gnt_idx  <= w_gnt_idx_d;
            r_grant    <= w_grant_d;
            r_ack      <= w_ack_d;
            r_tx_data  <= w_tx_data_d;
            r_tx_start <= w_tx_start_d;
            r_arb_busy <= w_arb_busy_d;
`ifdef UART_ARB_TIMEOUT_EN
            r_cnt      <= w_cnt_d;
            r_tx_err   <= w_tx_err_d;
`endif
        end
    end

    assign bus.Grant    = r_grant;
    assign bus.Ack      = r_ack;
    assign bus.Tx_data  = r_tx_data;
    assign bus.Tx_start = r_tx_start;
    assign bus.Arb_busy = r_arb_busy;
`ifdef UART_ARB_TIMEOUT_EN
    assign bus.Tx_err   = r_tx_err;
`else
    assign bus.Tx_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: reset, handshake timing, round robin,
// request drop with data change, reset mid-frame and the start watchdog.
module tb_uart_tx_arbiter;
    localparam int unsigned N_REQ       = 4;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned TIMEOUT_CYC = 16;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

    uart_tx_arbiter #(
        .N_REQ      (N_REQ),
        .DATA_W     (DATA_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .Clock_In(clk),
        .Reset   (rst_n),
        .bus     (bus)
    );

    int          n_asserts = 0;
    int          n_fail    = 0;
    logic [31:0] words [4];

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic apply_words();
        bus.Req_Data = {words[3], words[2], words[1], words[0]};
    endtask

    task automatic wait_grant(input int idx, input logic [31:0] exp_word);
        int k = 0;
        while (bus.Tx_start !== 1'b1 && k < 20) begin
            step();
            k++;
        end
        chk("start_seen", {63'd0, bus.Tx_start}, 64'd1);
        chk("grant", {60'd0, bus.Grant}, {60'd0, 4'b0001 << idx});
        chk("tx_data", {32'd0, bus.Tx_data}, {32'd0, exp_word});
    endtask

    task automatic busy_rise();
        int k = 0;
        step();
        step();
        bus.Tx_busy = 1'b1;
        while (bus.Tx_start !== 1'b0 && k < 10) begin
            step();
            k++;
        end
        chk("start_release", {63'd0, bus.Tx_start}, 64'd0);
    endtask

    task automatic busy_fall(input int idx);
        int k = 0;
        bus.Tx_busy = 1'b0;
        while (bus.Ack === 4'b0000 && k < 10) begin
            step();
            k++;
        end
        chk("ack", {60'd0, bus.Ack}, {60'd0, 4'b0001 << idx});
        step();
        chk("ack_one_cycle", {60'd0, bus.Ack}, 64'd0);
    endtask

    initial begin
        // Reset with every requester asking
        rst_n       = 1'b0;
        bus.Req     = 4'b1111;
        bus.Tx_busy = 1'b0;
        words[0] = 32'h0000_0011;
        words[1] = 32'h0000_0022;
        words[2] = 32'h0000_0033;
        words[3] = 32'h0000_0044;
        apply_words();
        repeat (3) step();
        chk("rst_grant",    {60'd0, bus.Grant},    64'd0);
        chk("rst_ack",      {60'd0, bus.Ack},      64'd0);
        chk("rst_tx_data",  {32'd0, bus.Tx_data},  64'd0);
        chk("rst_tx_start", {63'd0, bus.Tx_start}, 64'd0);
        chk("rst_tx_err",   {63'd0, bus.Tx_err},   64'd0);
        chk("rst_arb_busy", {63'd0, bus.Arb_busy}, 64'd0);

        // First grant after release
        words[0] = 32'hA5A5_0001;
        words[1] = 32'h0;
        words[2] = 32'h0000_00C2;
        words[3] = 32'h0;
        apply_words();
        bus.Req = 4'b0101;
        rst_n   = 1'b1;
        step();
        chk("first_grant",    {60'd0, bus.Grant},    64'h1);
        chk("first_tx_data",  {32'd0, bus.Tx_data},  64'hA5A5_0001);
        chk("first_tx_start", {63'd0, bus.Tx_start}, 64'd1);
        chk("first_arb_busy", {63'd0, bus.Arb_busy}, 64'd1);

        // Handshake timing: busy rises 3 cycles after start, high 40 cycles
        step();
        step();
        bus.Tx_busy = 1'b1;
        step();
        chk("start_after_u",  {63'd0, bus.Tx_start}, 64'd1);
        step();
        chk("start_after_u1", {63'd0, bus.Tx_start}, 64'd1);
        step();
        chk("start_after_u2", {63'd0, bus.Tx_start}, 64'd0);
        repeat (37) step();
        chk("busy_arb_busy", {63'd0, bus.Arb_busy}, 64'd1);
        chk("busy_no_ack",   {60'd0, bus.Ack},      64'd0);
        bus.Tx_busy = 1'b0;
        step();
        chk("ack_after_v",  {60'd0, bus.Ack}, 64'd0);
        step();
        chk("ack_after_v1", {60'd0, bus.Ack}, 64'd0);
        step();
        chk("ack_after_v2", {60'd0, bus.Ack}, 64'h1);
        bus.Req = 4'b0000;
        step();
        chk("ack_after_v3",  {60'd0, bus.Ack},      64'd0);
        chk("grant_cleared", {60'd0, bus.Grant},    64'd0);
        chk("arb_idle",      {63'd0, bus.Arb_busy}, 64'd0);

        // Round robin from a fresh pointer
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        words[0] = 32'h1111_0000;
        words[1] = 32'h2222_0001;
        words[2] = 32'h3333_0002;
        words[3] = 32'h4444_0003;
        apply_words();
        bus.Req = 4'b1111;
        for (int f = 0; f < 8; f++) begin
            wait_grant(f % 4, words[f % 4]);
            busy_rise();
            repeat (5) step();
            busy_fall(f % 4);
        end
        bus.Req = 4'b0000;
        step();

        // Requester 1 drops and rewrites its word while its frame is in flight
        words[1] = 32'h3C3C_0101;
        apply_words();
        bus.Req = 4'b0110;
        wait_grant(1, 32'h3C3C_0101);
        busy_rise();
        bus.Req  = 4'b0100;
        words[1] = 32'hDEAD_BEEF;
        apply_words();
        repeat (3) step();
        chk("captured_word", {32'd0, bus.Tx_data}, 64'h3C3C_0101);
        busy_fall(1);
        wait_grant(2, 32'h3333_0002);

        // Reset in the middle of requester 2's frame
        busy_rise();
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_grant",    {60'd0, bus.Grant},    64'd0);
        chk("midrst_ack",      {60'd0, bus.Ack},      64'd0);
        chk("midrst_tx_start", {63'd0, bus.Tx_start}, 64'd0);
        chk("midrst_tx_data",  {32'd0, bus.Tx_data},  64'd0);
        chk("midrst_arb_busy", {63'd0, bus.Arb_busy}, 64'd0);
        @(negedge clk);
        bus.Tx_busy = 1'b0;
        bus.Req     = 4'b1000;
        step();
        chk("midrst_held_ack", {60'd0, bus.Ack}, 64'd0);
        rst_n = 1'b1;
        step();
        chk("postrst_grant",    {60'd0, bus.Grant},    64'h8);
        chk("postrst_tx_start", {63'd0, bus.Tx_start}, 64'd1);

        // Transmitter never responds
`ifdef UART_ARB_TIMEOUT_EN
        begin
            int n = 1;
            step();
            while (bus.Tx_start === 1'b1 && n < 40) begin
                n++;
                step();
            end
            chk("wd_start_cycles", 64'(n), 64'd16);
            chk("wd_ack",    {60'd0, bus.Ack},    64'h8);
            chk("wd_err",    {63'd0, bus.Tx_err}, 64'd1);
            step();
            chk("wd_ack_clr", {60'd0, bus.Ack},    64'd0);
            chk("wd_err_clr", {63'd0, bus.Tx_err}, 64'd0);
        end
`else
        begin
            logic err_seen = 1'b0;
            logic ack_seen = 1'b0;
            repeat (1000) begin
                step();
                err_seen = err_seen | bus.Tx_err;
                ack_seen = ack_seen | (|bus.Ack);
            end
            chk("nowd_start_held", {63'd0, bus.Tx_start}, 64'd1);
            chk("nowd_err_never",  {63'd0, err_seen},     64'd0);
            chk("nowd_ack_never",  {63'd0, ack_seen},     64'd0);
        end
`endif
        bus.Req = 4'b0000;
        rst_n   = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter and sequencer that shares one UART transmitter among `N_REQ` requesters. Each requester presents a 32-bit word with a request; the block selects one, drives the transmitter's data and start inputs, and tracks the frame through the transmitter's busy flag. It acknowledges the winner when the frame has left the transmitter. It sits between client logic and the transmitter's `Data_In`/`Tx_start` inputs, in the `Clock_In` domain.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 32: word width; matches transmitter `Data_In`.
- `TIMEOUT_CYC`, 4096: start-handshake watchdog limit in `Clock_In` cycles. Used only with `UART_ARB_TIMEOUT_EN`.

Ports:
- `Clock_In`  in  1  system clock; all state is on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `Req`  in  N_REQ  per-requester request level.
- `Req_Data`  in  N_REQ*DATA_W  flattened words; requester i occupies bits `[i*DATA_W +: DATA_W]`.
- `Tx_busy`  in  1  transmitter frame-in-flight flag. It is asynchronous to `Clock_In` and is synchronized internally.
- `Grant`  out  N_REQ  one-hot index of the current owner.
- `Ack`  out  N_REQ  one-cycle completion pulse to the owner.
- `Tx_data`  out  DATA_W  word to the transmitter `Data_In`.
- `Tx_start`  out  1  start request to the transmitter.
- `Tx_err`  out  1  one-cycle pulse on a watchdog abort.
- `Arb_busy`  out  1  high in every state except IDLE.

## Operation
- **Busy synchronizer.** `Tx_busy` passes through a 2-flop synchronizer. `busy_s` is the synchronized value. All decisions use `busy_s`.
- **IDLE.** If `Req` is non-zero, select the first set bit at or after `ptr`, searching cyclically. Register the winner's word into `Tx_data`, set its `Grant` bit and set `Tx_start`. Go to START.
- **START.** Hold `Tx_start`, `Tx_data` and `Grant` stable. When `busy_s` is 1, clear `Tx_start` and go to BUSY.
- **BUSY.** When `busy_s` is 0, go to DONE.
- **DONE.** Pulse `Ack[g]`, where g is the granted index. Set `ptr` to (g+1) mod N_REQ and clear `Grant`. Go to IDLE.
- **Requester contract.** A requester holds `Req` and its data until its `Ack`. A `Req` that drops after grant is ignored: the frame completes and `Ack` still pulses.
- **Fairness.** A `Req` still high in the IDLE after its `Ack` is treated as a new request. Because `ptr` has advanced, every other pending requester is served before a repeat grant.
- **Data capture.** `Req_Data` is sampled only at the IDLE→START transition. Later changes have no effect on the frame in flight.
- **Reset mid-transfer.** All state clears immediately. `Tx_start` falls even if the transmitter is mid-frame. No `Ack` is issued. The next arbitration starts at `ptr` = 0.
- **Reset values.** `Grant` = 0, `Ack` = 0, `Tx_data` = 0, `Tx_start` = 0, `Tx_err` = 0, `Arb_busy` = 0. Internally, `ptr` = 0, the state is IDLE and the synchronizer is 0.

## Timing
- **Request to start.** `Req` is sampled in IDLE at edge T. `Tx_start`, `Grant` and `Tx_data` are valid after edge T.
- **Start release.** If `Tx_busy` rises just before edge U, `busy_s` is 1 after edge U+1. `Tx_start` falls after edge U+2.
- **Busy fall to Ack.** If `Tx_busy` falls just before edge V, `busy_s` is 0 after edge V+1. DONE is entered at edge V+2, so `Ack` is high for the cycle after edge V+2.
- **Back-to-back.** IDLE evaluates one cycle after DONE. The minimum gap between consecutive `Tx_start` assertions is therefore 1 idle cycle.
- **Registered outputs.** All outputs are registered, with no combinational path from input to output.

## Configuration
- **`UART_ARB_TIMEOUT_EN` defined.** A counter clears on entry to START and increments each cycle spent in START. If it reaches `TIMEOUT_CYC` − 1 with `busy_s` still 0, the block clears `Tx_start` and goes to DONE. `Ack[g]` and `Tx_err` pulse together in that DONE cycle, and `ptr` advances as normal. The counter is sized ⌈log2(TIMEOUT_CYC)⌉ bits.
- **`UART_ARB_TIMEOUT_EN` undefined.** The block waits in START indefinitely. No counter is synthesized and `Tx_err` is tied to 0.

## Test plan
- **Reset.** Assert `Reset`=0 with all `Req`=1 → every output is 0. After release with `Req`=4'b0101 and `Req_Data` word0=32'hA5A5_0001, word2=32'h0000_00C2: `Grant`=4'b0001, `Tx_data`=32'hA5A5_0001, `Tx_start`=1 one cycle later.
- **Handshake.** Model the transmitter: `Tx_busy` rises 3 cycles after `Tx_start` and stays high 40 cycles. Check `Tx_start` falls 2 cycles after `Tx_busy` rises, and `Ack`=4'b0001 pulses exactly 1 cycle, 3 cycles after `Tx_busy` falls.
- **Round robin.** Hold `Req`=4'b1111 for 8 frames → grant order 0,1,2,3,0,1,2,3, with one `Ack` per frame and `Tx_data` matching the granted word each time.
- **Req drop and data change.** Drop `Req[1]` and change its data mid-BUSY → the frame uses the captured word, `Ack[1]` still pulses, and requester 1 is not re-granted.
- **Reset mid-frame.** Assert `Reset` during BUSY → outputs are 0 next sample, with no `Ack`. After release with `Req`=4'b1000, `Grant`=4'b1000.
- **Watchdog.** With `UART_ARB_TIMEOUT_EN` and `TIMEOUT_CYC`=16, hold `Tx_busy`=0 → `Tx_start` high for 16 cycles, then `Ack` and `Tx_err` pulse together. Without the macro, `Tx_start` stays high after 1000 cycles and `Tx_err` stays 0.
